// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state encoding, the accepted opcode values and the
// iteration-counter width helper used by seq_multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] SIG_MULT  = 6'd24;  // signed multiply
  localparam logic [5:0] SIG_MULTU = 6'd25;  // unsigned multiply

  // Counter width for the default operand width; instances with another
  // WIDTH derive theirs through cnt_w_of() so the counter always fits WIDTH.
  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT + 1);

  function automatic int cnt_w_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: accumulator, left-shifting multiplicand, right-shifting multiplier.
// Latency: one iteration per i_step cycle; o_acc_nxt is the combinational result of the current step.
// Backpressure: none; the controller alone decides when to load and step.
// Ports: i_clk/i_rst clock and async reset, i_load latches operands and clears the
// accumulator, i_step performs one iteration, i_mcand/i_mplier operand magnitudes,
// o_acc_nxt accumulator value after the current step, o_mplier_nxt_zero multiplier
// becomes zero after the current step.
module mult_shift_add_dp
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic [2*WIDTH-1:0]   o_acc_nxt,
  output logic                 o_mplier_nxt_zero
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // Addition wraps modulo 2^(2*WIDTH); magnitudes never exceed that range.
  assign o_acc_nxt         = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_mplier_nxt_zero = (r_mplier[WIDTH-1:1] == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
    end else if (i_step) begin
      r_acc    <= o_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier: IDLE -> RUN (one bit per cycle) -> DONE.
// Latency: done in the (WIDTH+1)th cycle after the accepting edge (fewer with EARLY_EXIT).
// Backpressure: start is only honoured in IDLE; requests while busy or in DONE are dropped.
// Ports: clk, reset (async, active high), start/Signal/dataA/dataB request sampled in IDLE,
// busy high during iteration, done one-cycle pulse with dataOut valid, dataOut product
// held until the next done, err one-cycle pulse for an unrecognised Signal.
module seq_multiplier #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           Signal,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut,
  output logic                 err
);
  import seq_multiplier_pkg::*;

  localparam int CW = cnt_w_of(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_err;
  logic [2*WIDTH-1:0] r_data_out;

  logic               w_sig_ok;
  logic               w_is_signed;
  logic               w_load;
  logic               w_step;
  logic               w_finish;
  logic               w_err_set;
  logic               w_last;
  logic               w_mplier_nxt_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_sig_ok    = (Signal == SIG_MULT) || (Signal == SIG_MULTU);
  assign w_is_signed = (Signal == SIG_MULT);

  // Magnitudes fit WIDTH unsigned bits, including -2^(WIDTH-1) -> 2^(WIDTH-1).
  assign w_mag_a = (w_is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
  assign w_mag_b = (w_is_signed && dataB[WIDTH-1]) ? -dataB : dataB;

  // The counter still holds the pre-increment value during the final iteration.
  assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                  ((EARLY_EXIT != 0) && w_mplier_nxt_zero);

  mult_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .i_clk             (clk),
    .i_rst             (reset),
    .i_load            (w_load),
    .i_step            (w_step),
    .i_mcand           (w_mag_a),
    .i_mplier          (w_mag_b),
    .o_acc_nxt         (w_acc_nxt),
    .o_mplier_nxt_zero (w_mplier_nxt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_sig_ok) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_err_set   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_err <= w_err_set;
      if (w_load) begin
        r_cnt <= '0;
        r_neg <= w_is_signed && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
      end else if (w_step) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // Capture the final accumulator on the same edge that enters DONE.
      if (w_finish) begin
        r_data_out <= r_neg ? -w_acc_nxt : w_acc_nxt;
      end
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign dataOut = r_data_out;
  assign err     = r_err;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: three instances (WIDTH=32, WIDTH=8,
// WIDTH=32 with EARLY_EXIT=1) checked every cycle against a cycle-count/product
// model, plus directed literal expectations.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]        st;
  logic [2:0][5:0]   sg;
  logic [2:0][31:0]  da;
  logic [2:0][31:0]  db;
  logic [2:0]        bz, dn, er;
  logic [63:0]       do0, do2;
  logic [15:0]       do1;

  seq_multiplier #(.WIDTH(32), .EARLY_EXIT(0)) u_w32 (
    .clk(clk), .reset(reset), .start(st[0]), .Signal(sg[0]),
    .dataA(da[0]), .dataB(db[0]),
    .busy(bz[0]), .done(dn[0]), .dataOut(do0), .err(er[0]));

  seq_multiplier #(.WIDTH(8), .EARLY_EXIT(0)) u_w8 (
    .clk(clk), .reset(reset), .start(st[1]), .Signal(sg[1]),
    .dataA(da[1][7:0]), .dataB(db[1][7:0]),
    .busy(bz[1]), .done(dn[1]), .dataOut(do1), .err(er[1]));

  seq_multiplier #(.WIDTH(32), .EARLY_EXIT(1)) u_w32e (
    .clk(clk), .reset(reset), .start(st[2]), .Signal(sg[2]),
    .dataA(da[2]), .dataB(db[2]),
    .busy(bz[2]), .done(dn[2]), .dataOut(do2), .err(er[2]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
  endtask

  function automatic logic [63:0] dout(input int k);
    case (k)
      0:       return do0;
      1:       return {48'd0, do1};
      default: return do2;
    endcase
  endfunction

  function automatic int wid(input int k);
    return (k == 1) ? 8 : 32;
  endfunction

  // Exact product of the low w bits of a and b, reduced to 2w bits.
  function automatic logic [63:0] prod(input int w, input logic [5:0] s,
                                       input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, p;
    logic signed [63:0] sa, sb;
    ua = {32'd0, a} & ((64'd1 << w) - 64'd1);
    ub = {32'd0, b} & ((64'd1 << w) - 64'd1);
    if (s == 6'd25) begin
      p = ua * ub;
    end else begin
      sa = ua[w-1] ? $signed(ua - (64'd1 << w)) : $signed(ua);
      sb = ub[w-1] ? $signed(ub - (64'd1 << w)) : $signed(ub);
      p  = sa * sb;
    end
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Iterations: always w, or with early exit the bit length of the multiplier magnitude (min 1).
  function automatic int iters(input int w, input bit ee, input logic [5:0] s, input logic [31:0] b);
    logic [63:0] ub, mag;
    int n;
    if (!ee) return w;
    ub  = {32'd0, b} & ((64'd1 << w) - 64'd1);
    mag = (s == 6'd24 && ub[w-1]) ? ((64'd1 << w) - ub) : ub;
    n = 0;
    for (int i = 0; i < w; i++) if (mag[i]) n = i + 1;
    return (n == 0) ? 1 : n;
  endfunction

  // Behavioural model: after acceptance busy for L cycles, done in cycle L+1,
  // one more cycle before requests are honoured again.
  logic        e_busy [3];
  logic        e_done [3];
  logic        e_err  [3];
  logic [63:0] e_dout [3];
  bit          act    [3];
  int          cnt    [3];
  int          lat    [3];
  logic [63:0] res    [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0; e_dout[k] = '0;
      act[k] = 0; cnt[k] = 0; lat[k] = 0; res[k] = '0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0; e_dout[k] = '0; act[k] = 0;
        end else begin
          e_err[k]  = 0;
          e_done[k] = 0;
          if (act[k]) begin
            cnt[k]++;
            e_busy[k] = (cnt[k] <= lat[k]);
            if (cnt[k] == lat[k] + 1) begin
              e_done[k] = 1;
              e_dout[k] = res[k];
            end
            if (cnt[k] == lat[k] + 2) act[k] = 0;
          end else if (st[k]) begin
            if (sg[k] == 6'd24 || sg[k] == 6'd25) begin
              act[k]    = 1;
              cnt[k]    = 1;
              e_busy[k] = 1;
              res[k]    = prod(wid(k), sg[k], da[k], db[k]);
              lat[k]    = iters(wid(k), (k == 2), sg[k], db[k]);
            end else begin
              e_err[k] = 1;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy%0d", k), 64'(bz[k]), 64'(e_busy[k]));
        chk($sformatf("done%0d", k), 64'(dn[k]), 64'(e_done[k]));
        chk($sformatf("err%0d", k),  64'(er[k]), 64'(e_err[k]));
        chk($sformatf("dout%0d", k), dout(k), e_dout[k]);
      end
    end
  end

  task automatic op(input int k, input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                    output int cyc, output int nbusy, output logic [63:0] r);
    @(posedge clk); #1;
    st[k] = 1'b1; sg[k] = s; da[k] = a; db[k] = b;
    @(posedge clk); #1;
    st[k] = 1'b0;
    cyc = 0; nbusy = 0; r = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bz[k]) nbusy++;
      if (dn[k]) begin
        cyc = i;
        r   = dout(k);
        break;
      end
    end
    chk($sformatf("done_seen%0d", k), 64'(cyc > 0), 64'd1);
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int          cyc, nb, ndone, saw, r4;
  logic [63:0] r;

  initial begin
    reset = 1'b0; st = '0; sg = '0; da = '0; db = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), 64'(bz[k]), 64'd0);
      chk($sformatf("rst_done%0d", k), 64'(dn[k]), 64'd0);
      chk($sformatf("rst_err%0d", k),  64'(er[k]), 64'd0);
      chk($sformatf("rst_dout%0d", k), dout(k), 64'd0);
    end
    @(posedge clk); #1 reset = 1'b0;

    // Full-width unsigned: fixed latency and busy length.
    op(0, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, nb, r);
    chk("multu_max_lat", 64'(cyc), 64'd33);
    chk("multu_max_busy", 64'(nb), 64'd32);
    chk("multu_max_prod", r, 64'hFFFF_FFFE_0000_0001);

    // Signed cases, issued back-to-back.
    op(0, 6'd24, 32'hFFFF_FFFE, 32'h0000_0003, cyc, nb, r);
    chk("mult_neg2x3_lat", 64'(cyc), 64'd33);
    chk("mult_neg2x3", r, 64'hFFFF_FFFF_FFFF_FFFA);
    op(0, 6'd24, 32'h8000_0000, 32'h8000_0000, cyc, nb, r);
    chk("mult_minxmin", r, 64'h4000_0000_0000_0000);

    // Request at RUN cycle 10 and toggling dataA must not disturb the operation.
    @(posedge clk); #1;
    st[0] = 1'b1; sg[0] = 6'd25; da[0] = 32'd1000; db[0] = 32'd1000;
    @(posedge clk); #1;
    st[0] = 1'b0;
    ndone = 0; r = '0;
    for (int i = 1; i <= 40; i++) begin
      st[0] = (i == 10);
      if (i == 10) begin
        sg[0] = 6'd24; db[0] = 32'd5;
      end
      da[0] = ~da[0];
      @(negedge clk);
      if (dn[0]) begin
        ndone++;
        r = do0;
      end
      @(posedge clk); #1;
    end
    st[0] = 1'b0;
    chk("ignore_start_ndone", 64'(ndone), 64'd1);
    chk("ignore_start_prod", r, 64'd1000000);

    // Reset in RUN cycle 16 aborts with no done pulse.
    @(posedge clk); #1;
    st[0] = 1'b1; sg[0] = 6'd25; da[0] = 32'hFFFF; db[0] = 32'hFFFF;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (16) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bz[0]), 64'd0);
    chk("abort_done", 64'(dn[0]), 64'd0);
    chk("abort_dout", do0, 64'd0);
    saw = 0;
    repeat (2) begin
      @(negedge clk);
      if (dn[0]) saw++;
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dn[0]) saw++;
    end
    chk("abort_no_done", 64'(saw), 64'd0);
    op(0, 6'd25, 32'd7, 32'd6, cyc, nb, r);
    chk("post_reset_lat", 64'(cyc), 64'd33);
    chk("post_reset_7x6", r, 64'd42);

    // Unrecognised Signal: err pulse, no activity, result kept.
    @(posedge clk); #1;
    st[0] = 1'b1; sg[0] = 6'h3F; da[0] = 32'd5; db[0] = 32'd5;
    @(posedge clk); #1;
    st[0] = 1'b0; sg[0] = 6'd25;
    @(negedge clk);
    chk("bad_sig_err", 64'(er[0]), 64'd1);
    chk("bad_sig_busy", 64'(bz[0]), 64'd0);
    chk("bad_sig_dout", do0, 64'd42);
    @(negedge clk);
    chk("bad_sig_err_off", 64'(er[0]), 64'd0);
    chk("bad_sig_busy2", 64'(bz[0]), 64'd0);

    // Early exit.
    op(2, 6'd25, 32'd5, 32'd1, cyc, nb, r);
    chk("ee_5x1_lat", 64'(cyc), 64'd2);
    chk("ee_5x1", r, 64'd5);
    op(2, 6'd25, 32'd9, 32'd0, cyc, nb, r);
    chk("ee_9x0_lat", 64'(cyc), 64'd2);
    chk("ee_9x0", r, 64'd0);
    op(2, 6'd24, 32'hFFFF_FFFE, 32'd3, cyc, nb, r);
    chk("ee_neg2x3_lat", 64'(cyc), 64'd3);
    chk("ee_neg2x3", r, 64'hFFFF_FFFF_FFFF_FFFA);

    // WIDTH=8 corners.
    op(1, 6'd24, 32'h80, 32'h80, cyc, nb, r);
    chk("w8_minxmin_lat", 64'(cyc), 64'd9);
    chk("w8_minxmin", r, 64'h4000);
    op(1, 6'd24, 32'hFF, 32'h01, cyc, nb, r);
    chk("w8_neg1x1", r, 64'hFFFF);
    op(1, 6'd25, 32'hFF, 32'hFF, cyc, nb, r);
    chk("w8_ffxff", r, 64'hFE01);

    // Random regression on all instances; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        st[k] = ($urandom_range(0, 2) == 0);
        r4 = $urandom_range(0, 15);
        if (r4 == 0)      sg[k] = 6'($urandom_range(0, 63));
        else if (r4[0])   sg[k] = 6'd24;
        else              sg[k] = 6'd25;
        da[k] = pick(wid(k));
        db[k] = pick(wid(k));
      end
    end
    @(posedge clk); #1;
    st = '0;
    repeat (80) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
